swipt_frame_sequencer: RTL and testbench
========================================

Name: swipt_frame_sequencer

Overview:
Frame-level controller for the SWIPT downlink bit modulator. It accepts a payload word plus length over a start/busy/done handshake and generates the per-bit clock-enable strobe. It serialises a frame (fixed preamble, LSB-first payload, zero guard) onto a single modulation bit that feeds the carrier keying stage. It replaces free-running pattern playback with a sequenced, abortable transmission.

Parameters:
CLK_DIV, 100, i_clk cycles per transmitted bit; legal range 2..65535
PREAMBLE_BITS, 8, preamble length in bits; legal range 1..16
PREAMBLE_PATTERN, 16'h00AA, preamble bits, sent LSB first; only the low PREAMBLE_BITS bits are used
GUARD_BITS, 4, number of trailing zero bits; legal range 1..15

Ports:
i_clk  in  1  system clock
i_nrst  in  1  reset, asynchronous, active-low
i_enable  in  1  sequencer enable; deassertion aborts any frame in progress
i_start  in  1  frame request, sampled on the rising edge
i_data  in  32  payload, bit 0 sent first
i_len  in  6  payload length in bits; legal range 1..32
o_busy  out  1  frame in progress (any state other than IDLE)
o_done  out  1  one-cycle pulse on normal frame completion
o_abort  out  1  one-cycle pulse when a frame is killed by i_enable=0
o_err  out  1  one-cycle pulse when a start is rejected because i_len is illegal
o_bit  out  1  modulation bit
o_ce  out  1  one-cycle strobe in the last i_clk cycle of each bit period

Behaviour:
- Reset: all outputs 0; FSM in IDLE; counters 0.
- FSM states: IDLE -> PREAMBLE -> PAYLOAD -> GUARD -> IDLE.
- Bit timing:
  - A divider counter div_cnt counts 0..CLK_DIV-1 in every state except IDLE.
  - o_ce = 1 exactly when div_cnt == CLK_DIV-1 and the state is not IDLE (registered output).
  - Each bit occupies exactly CLK_DIV cycles.
  - The next bit is loaded onto o_bit at the edge that follows the o_ce cycle.
- Start acceptance:
  - In IDLE, when i_start=1, i_enable=1 and 1<=i_len<=32: latch i_data and i_len; at the same edge set div_cnt=0, bit index=0, o_bit=PREAMBLE_PATTERN[0], and state=PREAMBLE.
  - o_busy is high from the next cycle. Latency from start to the first bit is 1 cycle.
- Illegal length: i_len==0 or i_len>32 with i_start=1 and i_enable=1 in IDLE gives o_err=1 for one cycle and the FSM stays in IDLE.
- i_start outside IDLE is ignored: no error, and the latched data is unchanged.
- PREAMBLE: sends PREAMBLE_PATTERN[0..PREAMBLE_BITS-1], then goes to PAYLOAD with o_bit=data[0].
- PAYLOAD: sends data[0..len-1], then goes to GUARD with o_bit=0.
- GUARD: o_bit=0 for GUARD_BITS bit periods.
- Completion:
  - At the edge after the final GUARD o_ce, the FSM returns to IDLE with o_done=1, o_busy=0 and o_bit=0.
  - A start present in the o_done cycle is accepted, so back-to-back frames have a one-cycle idle gap.
- Frame duration: (PREAMBLE_BITS+len+GUARD_BITS)*CLK_DIV cycles of o_busy.
- Abort:
  - i_enable=0 in any non-IDLE state: at the next edge, state=IDLE, o_bit=0, o_abort=1 for one cycle, and no o_done.
  - Starts are ignored while i_enable=0.
- Bit index width is 6 bits; the index never exceeds 31 within PAYLOAD and never exceeds 15 within PREAMBLE/GUARD.
- o_done, o_abort and o_err are mutually exclusive in any cycle.
- Asynchronous reset mid-frame clears everything immediately. No done or abort pulse is generated.

Decomposition:
- Package swipt_pkg holds:
  - state enum (IDLE, PREAMBLE, PAYLOAD, GUARD, 2-bit encoding);
  - localparam MAX_LEN=32;
  - the widths for the divider counter and bit index.
- One natural sub-module, swipt_bit_tick: the CLK_DIV divider.
  - Inputs: run, clear.
  - Output: tick.
  - Reusable by the receiver-side sampler.

Test Plan (CLK_DIV=4, PREAMBLE_BITS=8, PREAMBLE_PATTERN=16'h00AA, GUARD_BITS=4):
1. Start accepted at edge t, i_data=32'h0000000B, i_len=4 -> o_bit sequence per 4-cycle period is 0,1,0,1,0,1,0,1 | 1,1,0,1 | 0,0,0,0; o_ce pulses 16 times; o_busy high t+1..t+64; o_done at t+65.
2. i_len=0, then i_len=33 with i_start -> o_err one cycle each; o_busy stays 0; o_bit stays 0.
3. i_enable dropped during payload bit 2 -> next cycle: o_abort=1, o_busy=0, o_bit=0; o_done never asserts.
4. i_start held high through the frame, i_len=32, i_data=32'hFFFFFFFF -> exactly one frame of 44 periods; a second frame starts in the o_done cycle, so the next o_busy rises one cycle after o_done.
5. i_start pulsed mid-frame with different i_data -> the transmitted payload equals the original latched data; no o_err.
6. i_nrst asserted mid-preamble -> all outputs 0 immediately; after release with a new start, the frame begins cleanly with PREAMBLE_PATTERN[0].

Source files
------------

// File: rtl/swipt_pkg.sv
// Shared types and widths for the SWIPT downlink frame sequencer and its bit-rate divider.
package swipt_pkg;

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_PREAMBLE = 2'd1,
    S_PAYLOAD  = 2'd2,
    S_GUARD    = 2'd3
  } state_e;

  localparam int MAX_LEN = 32;
  localparam int DIV_W   = 16;
  localparam int IDX_W   = 6;

endpackage

// File: rtl/swipt_bit_tick.sv
// Bit-period divider: counts CLK_DIV cycles while run is high and flags the last cycle of each period.
module swipt_bit_tick
  import swipt_pkg::*;
#(
  parameter int CLK_DIV = 100
) (
  input  logic i_clk,
  input  logic i_nrst,
  input  logic run,
  input  logic clear,
  output logic tick
);

  localparam logic [DIV_W-1:0] LAST = DIV_W'(CLK_DIV - 1);

  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic             tick_q, tick_d;

  // run and clear describe the coming cycle, so tick lands in the same cycle the counter reaches LAST
  always_comb begin
    cnt_d = '0;
    if (run && !clear) begin
      cnt_d = (cnt_q == LAST) ? '0 : cnt_q + DIV_W'(1);
    end
    tick_d = run && (cnt_d == LAST);
  end

  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      tick_q <= tick_d;
    end
  end

  assign tick = tick_q;

endmodule

// File: rtl/swipt_frame_sequencer.sv
// Frame sequencer: serialises preamble, LSB-first payload and zero guard onto o_bit, one bit per CLK_DIV cycles.
module swipt_frame_sequencer
  import swipt_pkg::*;
#(
  parameter int          CLK_DIV          = 100,
  parameter int          PREAMBLE_BITS    = 8,
  parameter logic [15:0] PREAMBLE_PATTERN = 16'h00AA,
  parameter int          GUARD_BITS       = 4
) (
  input  logic        i_clk,
  input  logic        i_nrst,
  input  logic        i_enable,
  input  logic        i_start,
  input  logic [31:0] i_data,
  input  logic [5:0]  i_len,
  output logic        o_busy,
  output logic        o_done,
  output logic        o_abort,
  output logic        o_err,
  output logic        o_bit,
  output logic        o_ce
);

  localparam logic [IDX_W-1:0] PRE_LAST   = IDX_W'(PREAMBLE_BITS - 1);
  localparam logic [IDX_W-1:0] GUARD_LAST = IDX_W'(GUARD_BITS - 1);

  state_e           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [31:0]      data_q, data_d;
  logic [5:0]       len_q, len_d;
  logic             bit_q, bit_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             abort_q, abort_d;
  logic             err_q, err_d;
  logic             start_ok;
  logic             tick;
  logic [3:0]       pre_nxt;
  logic [4:0]       pay_nxt;

  assign pre_nxt = idx_q[3:0] + 4'd1;
  assign pay_nxt = idx_q[4:0] + 5'd1;

  swipt_bit_tick #(.CLK_DIV(CLK_DIV)) u_tick (
    .i_clk  (i_clk),
    .i_nrst (i_nrst),
    .run    (state_d != S_IDLE),
    .clear  (start_ok),
    .tick   (tick)
  );

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    data_d   = data_q;
    len_d    = len_q;
    bit_d    = bit_q;
    done_d   = 1'b0;
    abort_d  = 1'b0;
    err_d    = 1'b0;
    start_ok = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        bit_d = 1'b0;
        if (i_start && i_enable) begin
          if (i_len != 6'd0 && i_len <= 6'(MAX_LEN)) begin
            start_ok = 1'b1;
            data_d   = i_data;
            len_d    = i_len;
            idx_d    = '0;
            bit_d    = PREAMBLE_PATTERN[0];
            state_d  = S_PREAMBLE;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      S_PREAMBLE: if (tick) begin
        if (idx_q == PRE_LAST) begin
          state_d = S_PAYLOAD;
          idx_d   = '0;
          bit_d   = data_q[0];
        end else begin
          idx_d = idx_q + IDX_W'(1);
          bit_d = PREAMBLE_PATTERN[pre_nxt];
        end
      end
      S_PAYLOAD: if (tick) begin
        if (idx_q == len_q - 6'd1) begin
          state_d = S_GUARD;
          idx_d   = '0;
          bit_d   = 1'b0;
        end else begin
          idx_d = idx_q + IDX_W'(1);
          bit_d = data_q[pay_nxt];
        end
      end
      S_GUARD: if (tick) begin
        if (idx_q == GUARD_LAST) begin
          state_d = S_IDLE;
          idx_d   = '0;
          done_d  = 1'b1;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase

    // losing enable overrides everything, including a completion on the same edge
    if (state_q != S_IDLE && !i_enable) begin
      state_d = S_IDLE;
      idx_d   = '0;
      bit_d   = 1'b0;
      done_d  = 1'b0;
      abort_d = 1'b1;
    end

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      data_q  <= '0;
      len_q   <= '0;
      bit_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      abort_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      data_q  <= data_d;
      len_q   <= len_d;
      bit_q   <= bit_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      abort_q <= abort_d;
      err_q   <= err_d;
    end
  end

  assign o_busy  = busy_q;
  assign o_done  = done_q;
  assign o_abort = abort_q;
  assign o_err   = err_q;
  assign o_bit   = bit_q;
  assign o_ce    = tick;

endmodule

// File: tb/tb_swipt_frame_sequencer.sv
// Self-checking bench for swipt_frame_sequencer: a frame-level model (bit array plus cycle position) checked every cycle.
module tb_swipt_frame_sequencer;

  localparam int          CLK_DIV  = 4;
  localparam int          PRE_BITS = 8;
  localparam logic [15:0] PATTERN  = 16'h00AA;
  localparam int          GUARD    = 4;

  logic        clk = 1'b0;
  logic        nrst = 1'b0;
  logic        en = 1'b0;
  logic        start = 1'b0;
  logic [31:0] data = '0;
  logic [5:0]  len = '0;
  logic        o_busy, o_done, o_abort, o_err, o_bit, o_ce;

  int n_checks = 0;
  int n_fails  = 0;

  // frame model: expected bit list and position in cycles from frame acceptance
  logic        m_active = 1'b0;
  logic [63:0] m_bits   = '0;
  int          m_nbits  = 0;
  int          m_pos    = 0;
  logic        m_done   = 1'b0;
  logic        m_abort  = 1'b0;
  logic        m_err    = 1'b0;

  logic [63:0] cap = '0;
  int          ce_cnt = 0;
  int          busy_cnt = 0;
  int          done_cnt = 0;
  int          err_cnt = 0;

  swipt_frame_sequencer #(
    .CLK_DIV(CLK_DIV), .PREAMBLE_BITS(PRE_BITS),
    .PREAMBLE_PATTERN(PATTERN), .GUARD_BITS(GUARD)
  ) dut (
    .i_clk(clk), .i_nrst(nrst), .i_enable(en), .i_start(start),
    .i_data(data), .i_len(len),
    .o_busy(o_busy), .o_done(o_done), .o_abort(o_abort), .o_err(o_err),
    .o_bit(o_bit), .o_ce(o_ce)
  );

  always #5 clk = ~clk;

  always @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      m_active = 1'b0;
      m_pos    = 0;
      m_done   = 1'b0;
      m_abort  = 1'b0;
      m_err    = 1'b0;
    end else begin
      logic [15:0] pat;
      pat     = PATTERN;
      m_done  = 1'b0;
      m_abort = 1'b0;
      m_err   = 1'b0;
      if (m_active) begin
        if (!en) begin
          m_active = 1'b0;
          m_abort  = 1'b1;
        end else begin
          m_pos++;
          if (m_pos == m_nbits * CLK_DIV) begin
            m_active = 1'b0;
            m_done   = 1'b1;
          end
        end
      end else if (start && en) begin
        if (len >= 1 && len <= 32) begin
          m_bits = '0;
          for (int i = 0; i < PRE_BITS; i++) m_bits[i] = pat[i];
          for (int i = 0; i < int'(len); i++) m_bits[PRE_BITS + i] = data[i];
          m_nbits  = PRE_BITS + int'(len) + GUARD;
          m_pos    = 0;
          m_active = 1'b1;
        end else begin
          m_err = 1'b1;
        end
      end
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_output();
    logic e_bit, e_ce;
    e_bit = m_active ? m_bits[m_pos / CLK_DIV] : 1'b0;
    e_ce  = m_active && ((m_pos % CLK_DIV) == CLK_DIV - 1);
    check("o_busy",  64'(o_busy),  64'(m_active));
    check("o_bit",   64'(o_bit),   64'(e_bit));
    check("o_ce",    64'(o_ce),    64'(e_ce));
    check("o_done",  64'(o_done),  64'(m_done));
    check("o_abort", 64'(o_abort), 64'(m_abort));
    check("o_err",   64'(o_err),   64'(m_err));
  endtask

  task automatic step_cycle();
    @(negedge clk);
    check_output();
    if (o_ce) begin
      if (ce_cnt < 64) cap[ce_cnt] = o_bit;
      ce_cnt++;
    end
    if (o_busy) busy_cnt++;
    if (o_done) done_cnt++;
    if (o_err)  err_cnt++;
    #1;
  endtask

  task automatic clear_counts();
    cap = '0; ce_cnt = 0; busy_cnt = 0; done_cnt = 0; err_cnt = 0;
  endtask

  task automatic apply_stimulus(input logic [31:0] d, input logic [5:0] l);
    data  = d;
    len   = l;
    start = 1'b1;
    step_cycle();
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget, input string name);
    for (int k = 0; k < budget; k++) begin
      step_cycle();
      if (o_done) break;
    end
    check(name, 64'(o_done), 64'd1);
  endtask

  initial begin
    repeat (3) step_cycle();
    check("reset_busy", 64'(o_busy), 64'd0);
    check("reset_bit",  64'(o_bit),  64'd0);
    check("reset_ce",   64'(o_ce),   64'd0);
    check("reset_done", 64'(o_done), 64'd0);
    nrst = 1'b1;
    en   = 1'b1;
    repeat (2) step_cycle();

    // 1: basic frame, 4-bit payload 1011 sent LSB first
    clear_counts();
    apply_stimulus(32'h0000000B, 6'd4);
    repeat (64) step_cycle();
    check("t1_done",     64'(o_done), 64'd1);
    check("t1_busy_end", 64'(o_busy), 64'd0);
    check("t1_busy_cnt", 64'(busy_cnt), 64'd64);
    check("t1_ce_cnt",   64'(ce_cnt), 64'd16);
    check("t1_bits",     64'(cap[15:0]), 64'h0BAA);
    repeat (2) step_cycle();

    // 2: illegal lengths
    data  = 32'h12345678;
    len   = 6'd0;
    start = 1'b1;
    step_cycle();
    check("t2_err0",  64'(o_err),  64'd1);
    check("t2_busy0", 64'(o_busy), 64'd0);
    len = 6'd33;
    step_cycle();
    check("t2_err33", 64'(o_err),  64'd1);
    check("t2_bit33", 64'(o_bit),  64'd0);
    start = 1'b0;
    step_cycle();
    check("t2_err_clr", 64'(o_err), 64'd0);

    // 3: abort during payload bit 2, then starts ignored while disabled
    clear_counts();
    apply_stimulus(32'h0000000B, 6'd4);
    repeat (41) step_cycle();
    en = 1'b0;
    step_cycle();
    check("t3_abort", 64'(o_abort), 64'd1);
    check("t3_busy",  64'(o_busy),  64'd0);
    check("t3_bit",   64'(o_bit),   64'd0);
    start = 1'b1;
    repeat (20) step_cycle();
    start = 1'b0;
    check("t3_no_done", 64'(done_cnt), 64'd0);
    check("t3_no_err",  64'(err_cnt),  64'd0);
    en = 1'b1;
    step_cycle();

    // 4: start held high, full-length payload, back-to-back restart
    clear_counts();
    data  = 32'hFFFFFFFF;
    len   = 6'd32;
    start = 1'b1;
    wait_done(400, "t4_done");
    check("t4_busy_cnt", 64'(busy_cnt), 64'd176);
    check("t4_ce_cnt",   64'(ce_cnt),   64'd44);
    step_cycle();
    check("t4_restart", 64'(o_busy), 64'd1);
    start = 1'b0;
    en    = 1'b0;
    step_cycle();
    en = 1'b1;
    step_cycle();

    // 5: mid-frame start with other data must not disturb the latched payload
    clear_counts();
    apply_stimulus(32'h0000005C, 6'd8);
    repeat (20) step_cycle();
    data  = 32'hFFFF0000;
    len   = 6'd3;
    start = 1'b1;
    step_cycle();
    start = 1'b0;
    wait_done(200, "t5_done");
    check("t5_ce_cnt",  64'(ce_cnt),   64'd20);
    check("t5_payload", 64'(cap[15:8]), 64'h5C);
    check("t5_no_err",  64'(err_cnt),  64'd0);
    step_cycle();

    // 6: asynchronous reset mid-preamble, then a clean restart
    clear_counts();
    apply_stimulus(32'h00000003, 6'd2);
    repeat (10) step_cycle();
    nrst = 1'b0;
    #1;
    check("t6_rst_busy", 64'(o_busy), 64'd0);
    check("t6_rst_bit",  64'(o_bit),  64'd0);
    check("t6_rst_ce",   64'(o_ce),   64'd0);
    check("t6_rst_flags", 64'({o_done, o_abort, o_err}), 64'd0);
    repeat (2) step_cycle();
    nrst = 1'b1;
    step_cycle();
    clear_counts();
    apply_stimulus(32'h00000003, 6'd2);
    check("t6_busy", 64'(o_busy), 64'd1);
    check("t6_bit0", 64'(o_bit),  64'd0);
    repeat (4) step_cycle();
    check("t6_bit1", 64'(o_bit),  64'd1);
    wait_done(100, "t6_done");
    check("t6_bits", 64'(cap[13:0]), 64'h03AA);
    repeat (2) step_cycle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
